// File: rtl/control_flow_unit_l5_if.sv
// Handshake bundles around the control flow execute unit.
// control_flow_unit_l5_dx_if carries issued instructions from decode into execute.
// control_flow_unit_l5_xw_if carries resolved results from execute to writeback.

interface control_flow_unit_l5_dx_if #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic                      rdy;
  logic [31:0]               pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [31:0]               op1;
  logic [31:0]               op2;
  logic [31:0]               op3;
  logic [4:0]                waddr;
  logic [3:0]                uop;

  modport master (output val, pc, seq_num, op1, op2, op3, waddr, uop, input rdy);
  modport slave  (input val, pc, seq_num, op1, op2, op3, waddr, uop, output rdy);
endinterface

interface control_flow_unit_l5_xw_if #(
  parameter int unsigned p_seq_num_bits = 5
);
  logic                      val;
  logic                      rdy;
  logic [31:0]               pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [4:0]                waddr;
  logic [31:0]               wdata;
  logic                      wen;

  modport master (output val, pc, seq_num, waddr, wdata, wen, input rdy);
  modport slave  (input val, pc, seq_num, waddr, wdata, wen, output rdy);
endinterface

// File: rtl/control_flow_unit_l5.sv
// Control flow execute unit: resolves JAL, JALR and conditional branches on entry
// into an elastic pipeline of p_num_stages slots. A taken transfer redirects fetch
// when it leaves the last slot and squashes everything younger still inside the unit.

module control_flow_unit_l5 #(
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_num_stages   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  control_flow_unit_l5_dx_if.slave  D,
  control_flow_unit_l5_xw_if.master W,
  output logic                      redirect_val,
  output logic [31:0]               redirect_target,
  output logic [p_seq_num_bits-1:0] redirect_seq_num
);

  localparam logic [3:0] OpJal  = 4'd1;
  localparam logic [3:0] OpJalr = 4'd2;
  localparam logic [3:0] OpBeq  = 4'd3;
  localparam logic [3:0] OpBne  = 4'd4;
  localparam logic [3:0] OpBlt  = 4'd5;
  localparam logic [3:0] OpBge  = 4'd6;
  localparam logic [3:0] OpBltu = 4'd7;
  localparam logic [3:0] OpBgeu = 4'd8;

  localparam int unsigned Last = p_num_stages - 1;

  typedef struct packed {
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    logic [31:0]               wdata;
    logic                      wen;
    logic                      taken;
    logic [31:0]               target;
  } stage_t;

  logic [p_num_stages-1:0] valid_q, valid_d;
  stage_t                  stage_q [p_num_stages];
  stage_t                  stage_d [p_num_stages];

  // go[k]: slot k hands its instruction on this cycle (to slot k+1, or to W for the last)
  logic [p_num_stages-1:0] go;
  logic                    redirect;
  logic                    accept;

  stage_t      entry;
  logic [31:0] pc_imm, pc_plus4, rs1_imm;
  logic        br_eq, br_lt, br_ltu;

  // Resolve the incoming instruction; all arithmetic wraps modulo 2^32
  always_comb begin
    pc_imm   = D.pc + D.op3;
    pc_plus4 = D.pc + 32'd4;
    rs1_imm  = D.op1 + D.op3;
    br_eq    = (D.op1 == D.op2);
    br_lt    = ($signed(D.op1) < $signed(D.op2));
    br_ltu   = (D.op1 < D.op2);

    entry         = '0;
    entry.pc      = D.pc;
    entry.seq_num = D.seq_num;
    entry.waddr   = D.waddr;
    entry.target  = pc_imm;
    case (D.uop)
      OpJal: begin
        entry.wen   = 1'b1;
        entry.wdata = pc_plus4;
        entry.taken = 1'b1;
      end
      OpJalr: begin
        entry.wen    = 1'b1;
        entry.wdata  = pc_plus4;
        entry.taken  = 1'b1;
        entry.target = rs1_imm & ~32'h1;
      end
      OpBeq:   entry.taken = br_eq;
      OpBne:   entry.taken = ~br_eq;
      OpBlt:   entry.taken = br_lt;
      OpBge:   entry.taken = ~br_lt;
      OpBltu:  entry.taken = br_ltu;
      OpBgeu:  entry.taken = ~br_ltu;
      // Unknown uops flow through as no-ops: no write, no redirect
      default: ;
    endcase
  end

  // Pass-through ready chain from W back to D, plus redirect detection
  always_comb begin
    go       = '0;
    go[Last] = valid_q[Last] & W.rdy;
    for (int k = int'(p_num_stages) - 2; k >= 0; k--) begin
      go[k] = valid_q[k] & (~valid_q[k+1] | go[k+1]);
    end
    redirect = go[Last] & stage_q[Last].taken;
    // Ingress is closed during a redirect so nothing wrong-path slips in
    D.rdy    = (~valid_q[0] | go[0]) & ~redirect;
    accept   = D.val & D.rdy;
  end

  // Next-state for the slots: shift on handshake, squash everything on redirect
  always_comb begin
    valid_d = valid_q;
    stage_d = stage_q;
    if (redirect) begin
      // The redirecting instruction drains to W; every other slot is younger
      valid_d = '0;
    end else begin
      for (int k = 1; k < int'(p_num_stages); k++) begin
        if (go[k-1]) begin
          valid_d[k] = 1'b1;
          stage_d[k] = stage_q[k-1];
        end else if (go[k]) begin
          valid_d[k] = 1'b0;
        end
      end
      if (accept) begin
        valid_d[0] = 1'b1;
        stage_d[0] = entry;
      end else if (go[0]) begin
        valid_d[0] = 1'b0;
      end
    end
  end

  // Slot registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < int'(p_num_stages); k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < int'(p_num_stages); k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // W and redirect come straight from the last slot, so they hold while W stalls
  always_comb begin
    W.val            = valid_q[Last];
    W.pc             = stage_q[Last].pc;
    W.seq_num        = stage_q[Last].seq_num;
    W.waddr          = stage_q[Last].waddr;
    W.wdata          = stage_q[Last].wdata;
    W.wen            = stage_q[Last].wen;
    redirect_val     = redirect;
    redirect_target  = stage_q[Last].target;
    redirect_seq_num = stage_q[Last].seq_num;
  end

endmodule

// File: doc/control_flow_unit_l5.md
# control_flow_unit_l5

Parametrised successor to the L4 control flow execute unit: resolves JAL, JALR and all six conditional branches in a configurable-depth elastic pipeline between decode/issue (D) and writeback (W). Every taken control transfer emits a one-cycle redirect to fetch and flushes the younger in-flight work inside the unit. The unit is instantiated in the execute stage alongside the ALU, multiply and memory units.

## Interface

- p_seq_num_bits, 5, width of sequence number
- p_num_stages, 1, pipeline depth (1..4); each stage holds one instruction

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- D  D__XIntf(p_seq_num_bits)  —  consumer side; uses val, rdy, pc, seq_num, op1 (rs1), op2 (rs2), op3 (imm), waddr, uop; preg and ppreg are ignored
- W  X__WIntf(p_seq_num_bits)  —  producer side; drives val, pc, seq_num, waddr, wdata, wen; samples rdy
- redirect_val     out  1   taken transfer resolved this cycle
- redirect_target  out  32  new fetch PC
- redirect_seq_num out  p_seq_num_bits  seq_num of the redirecting instruction

## Operation

- Accepted uops: OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU. Any other uop is accepted and passed through with wen=0 and no redirect.
- Computation happens in stage 0; later stages only carry results.
  - JAL: wdata = pc+4, wen=1, target = pc+imm, taken.
  - JALR: wdata = pc+4, wen=1, target = (op1+imm) & ~32'h1, taken.
  - Branches: wen=0, wdata=0. BLT/BGE use a signed compare; BLTU/BGEU use an unsigned compare. Taken ⇒ target = pc+imm.
- All additions are 32-bit modulo; overflow wraps.
- Stage k holds a valid bit plus the payload (pc, seq_num, waddr, wdata, wen, taken, target).
  - A stage advances when it is valid and the next stage is empty or draining.
  - The last stage drains on W.val & W.rdy.
  - D.rdy = stage 0 empty or advancing, and not flushing.
- Redirect:
  - Fires combinationally in the cycle the last stage completes its W handshake, when taken=1.
  - redirect_target and redirect_seq_num come from that stage.
  - No redirect fires while W.rdy=0; the instruction waits.
- Flush: in a redirect cycle, every other valid stage is cleared at the clock edge. Those instructions are younger and on the wrong path; they never reach W.
  - D.rdy=0 in the redirect cycle, so no new instruction is captured.
- In-order: W output order equals D acceptance order.

## Timing

- Reset: all valid bits 0; W.val=0, redirect_val=0, D.rdy=1 in the cycle after rst deasserts. rst asserted mid-operation discards all in-flight instructions with no W or redirect output.
- Latency: an instruction accepted at edge n appears on W.val after edge n+p_num_stages-1, i.e. combinationally in the cycle following the accept for p_num_stages=1.
- Throughput: one instruction per cycle with W.rdy=1 and no taken transfers.
- Full: all stages valid and W.rdy=0 ⇒ D.rdy=0. When W.rdy rises, D.rdy rises in the same cycle (pass-through ready).
- W payload is held stable while W.val=1 & W.rdy=0.
- Simultaneous D accept and W drain in one cycle is allowed, except in redirect cycles.

## Test plan

- JAL, p_num_stages=1: pc=0x100, imm=0x20, waddr=1 → W: pc=0x100, waddr=1, wdata=0x104, wen=1; redirect_target=0x120 in the same cycle as the W handshake.
- JALR: op1=0x2003, imm=0x4 → target=0x2006 (LSB cleared), wdata=pc+4. Also op1=0xFFFFFFFC, imm=8 → target=0x4 (wrap).
- Branches: BLT op1=0xFFFFFFFF, op2=1 → taken. BLTU with the same operands → not taken: wen=0, no redirect. BEQ/BNE/BGE/BGEU each checked both taken and not-taken.
- Flush, p_num_stages=3: send taken BEQ (seq 2), then ADD-like uop (seq 3) and JAL (seq 4) back to back → only seq 2 reaches W, one redirect fires, D.rdy=0 in the redirect cycle, and the next sent instruction (seq 5) is delivered normally.
- Backpressure: W.rdy held 0 for 3 cycles with all stages full → D.rdy=0, W payload stable, no redirect until the handshake. Repeat with random src/sink delays 0–3 and seq_num widths 3, 6, 9, including seq_num wrap.
- Reset mid-stream: assert rst with 2 instructions in flight → no W output and no redirect afterwards; the first post-reset instruction is delivered correctly.
